// File: rtl/video_fifo_axi_wr.sv
// video_fifo_axi_wr: FIFO-to-AXI4 burst writer over a wrapping frame; define VIDEO_WR_BRESP_CHECK_EN for sticky err on non-OKAY bresp
module video_fifo_axi_wr #(
    parameter int                    DATA_WIDTH   = 256,
    parameter int                    ADDR_WIDTH   = 28,
    parameter int                    LEVEL_WIDTH  = 9,
    parameter int                    BURST_LEN    = 16,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = '0,
    parameter int                    FRAME_BURSTS = 3600
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      frame_start,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    input  logic [LEVEL_WIDTH-1:0]    fifo_rd_water_level,
    output logic                      fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic                      busy,
    output logic                      err
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int BW = $clog2(FRAME_BURSTS + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         fetched, beat;
    logic [BW-1:0]         burst_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] head_q, tail_q;
    logic [1:0]            occ;
    logic                  in_flight, pend_restart, pop, last_beat, resp_done, wrap;

    assign pop       = m_wvalid && m_wready;
    assign last_beat = beat == CW'(BURST_LEN - 1);
    assign resp_done = state == RESP && m_bvalid;
    assign wrap      = pend_restart || frame_start || burst_cnt == BW'(FRAME_BURSTS - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN) && !frame_start ? ADDR : IDLE;
            ADDR: state_nx = m_awready ? DATA : ADDR;
            DATA: state_nx = pop && last_beat ? RESP : DATA;
            RESP: state_nx = m_bvalid ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // a word in flight from the FIFO is presented directly, so the first beat follows the AW cycle
    assign m_wvalid   = state == DATA && (occ != 2'd0 || in_flight);
    assign m_wdata    = occ != 2'd0 ? head_q : in_flight ? fifo_rd_data : '0;
    assign m_wlast    = m_wvalid && last_beat;
    assign m_wstrb    = '1;
    assign m_awvalid  = state == ADDR;
    assign m_awaddr   = addr;
    assign m_awlen    = 8'(BURST_LEN - 1);
    assign m_bready   = state == RESP;
    assign busy       = state != IDLE;
    assign fifo_rd_en = (state == ADDR || state == DATA) && ({1'b0, occ} + {2'b0, in_flight} < 3'd2)
                        && fetched < CW'(BURST_LEN) && fifo_rd_water_level != '0;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state        <= IDLE;
            addr         <= FRAME_BASE;
            burst_cnt    <= '0;
            pend_restart <= 1'b0;
            fetched      <= '0;
            beat         <= '0;
            occ          <= '0;
            in_flight    <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            state        <= state_nx;
            in_flight    <= fifo_rd_en;
            fetched      <= state == IDLE ? '0 : fetched + CW'(fifo_rd_en);
            beat         <= state == IDLE ? '0 : beat + CW'(pop);
            occ          <= occ + 2'(in_flight) - 2'(pop);
            head_q       <= pop ? (occ == 2'd2 ? tail_q : fifo_rd_data) : (occ == 2'd0 ? fifo_rd_data : head_q);
            tail_q       <= pop || occ == 2'd1 ? fifo_rd_data : tail_q;
            pend_restart <= state == IDLE || resp_done ? 1'b0 : pend_restart | frame_start;
            if ((state == IDLE && frame_start) || (resp_done && wrap)) begin
                addr      <= FRAME_BASE;
                burst_cnt <= '0;
            end else if (resp_done) begin
                addr      <= addr + STEP;
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

`ifdef VIDEO_WR_BRESP_CHECK_EN
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            err <= 1'b0;
        else if (resp_done && m_bresp != 2'b00)
            err <= 1'b1;
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^m_bresp;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_video_fifo_axi_wr.sv
// tb_video_fifo_axi_wr: randomized FIFO/AXI slave model with a queue-based scoreboard for video_fifo_axi_wr
module tb_video_fifo_axi_wr;
    localparam int DW = 256, AW = 28, LW = 9, BL = 16, FB = 4;
    localparam int BYTES = BL * DW / 8;
    localparam logic [AW-1:0] BASE = '0;
`ifdef VIDEO_WR_BRESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int level;
        bit exp_aw;
    } vec_t;

    logic clk = 1'b0, tb_rst = 1'b1, frame_start = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic [LW-1:0] fifo_rd_water_level = '0;
    logic fifo_rd_en, m_awvalid, m_wlast, m_wvalid, m_bready, busy, err;
    logic [AW-1:0] m_awaddr;
    logic [7:0] m_awlen;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [1:0] m_bresp = 2'b00;

    video_fifo_axi_wr #(.FRAME_BURSTS(FB)) dut (
        .clk(clk), .tb_rst(tb_rst), .frame_start(frame_start),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$], exp_w[$];
    logic [AW-1:0] aw_log[$];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic hold_last;
    bit rd_pend, aw_open, err_exp, stall_aw, stall_w, rand_w, rand_b, rand_push;
    int n_cmp, n_bad, n_rd, n_beats, wbeat, bnum, b_done, to_push, aw_wait;
    int aw_delay = 0, bad_burst = -1;
    vec_t tbl[6];

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic set_level();
        fifo_rd_water_level = q.size() > 511 ? 9'd511 : LW'(q.size());
    endtask

    task automatic push_n(int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd_word();
            q.push_back(w);
            exp_w.push_back(w);
        end
        set_level();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        tb_rst = 1'b1;
        frame_start = 1'b0;
        q.delete(); exp_w.delete(); aw_log.delete();
        aw_open = 0; bnum = 0; b_done = 0; err_exp = 0; to_push = 0;
        set_level();
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_awaddr", m_awaddr, BASE);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_wlast", m_wlast, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        repeat (20) @(posedge clk);
        #2 tb_rst = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((exp_w.size() != 0 || q.size() != 0 || to_push != 0 || busy) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_in_time", n < budget, 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // FIFO read port and AXI slave responses, driven just after each rising edge
    initial forever begin
        @(posedge clk); #1;
        fifo_rd_data = rd_pend && q.size() != 0 ? q.pop_front() : rnd_word();
        if (to_push > 0 && (!rand_push || $urandom_range(0, 1) == 1)) begin
            push_n(1);
            to_push--;
        end
        set_level();
        aw_wait   = m_awvalid ? aw_wait + 1 : 0;
        m_awready = m_awvalid && aw_wait > aw_delay;
        m_wready  = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
        m_bvalid  = m_bready && (rand_b ? 1'($urandom_range(0, 1)) : 1'b1);
        m_bresp   = b_done == bad_burst ? 2'b10 : 2'b00;
    end

    // scoreboard, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (tb_rst) begin
            rd_pend = 0; stall_aw = 0; stall_w = 0;
        end else begin
            if (fifo_rd_en) begin
                n_rd++;
                chk("pop_nonempty", q.size() != 0, 1);
            end
            rd_pend = fifo_rd_en;
            chk("err", err, err_exp);
            if (stall_aw) begin
                chk("awvalid_hold", m_awvalid, 1);
                chk("awaddr_hold", m_awaddr, hold_addr);
            end
            if (stall_w) begin
                chk("wvalid_hold", m_wvalid, 1);
                chk("wdata_hold", m_wdata, hold_data);
                chk("wlast_hold", m_wlast, hold_last);
            end
            stall_aw = m_awvalid && !m_awready; hold_addr = m_awaddr;
            stall_w = m_wvalid && !m_wready; hold_data = m_wdata; hold_last = m_wlast;
            if (m_wvalid && !aw_open) chk("wvalid_before_aw", m_wvalid, 0);
            if (m_awvalid && m_awready) begin
                chk("awaddr", m_awaddr, BASE + AW'((bnum % FB) * BYTES));
                chk("awlen", m_awlen, BL - 1);
                aw_log.push_back(m_awaddr);
                bnum++; aw_open = 1; wbeat = 0;
            end
            if (m_wvalid && m_wready && aw_open) begin
                chk("wdata_avail", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) chk("wdata", m_wdata, exp_w.pop_front());
                chk("wlast", m_wlast, wbeat == BL - 1);
                chk("wstrb", m_wstrb, {(DW/8){1'b1}});
                wbeat++; n_beats++;
                if (wbeat == BL) aw_open = 0;
            end
            if (m_bvalid && m_bready) begin
                b_done++;
                if (CHK && m_bresp != 2'b00) err_exp = 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bc, r0, b0, n;
        tbl[0] = '{0, 0};  tbl[1] = '{1, 0};  tbl[2] = '{15, 0};
        tbl[3] = '{16, 1}; tbl[4] = '{17, 1}; tbl[5] = '{300, 1};

        aw_delay = 1000;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            push_n(tbl[i].level);
            @(posedge clk); #2;
            chk("tbl_awvalid", m_awvalid, tbl[i].exp_aw);
            chk("tbl_rd_en", fifo_rd_en, tbl[i].exp_aw);
            chk("tbl_busy", busy, tbl[i].exp_aw);
            if (tbl[i].exp_aw) begin
                chk("tbl_awaddr", m_awaddr, BASE);
                chk("tbl_awlen", m_awlen, BL - 1);
            end
        end

        aw_delay = 0;
        do_reset();
        push_n(15);
        repeat (3) begin
            @(posedge clk); #2;
            chk("lvl15_awvalid", m_awvalid, 0);
        end
        push_n(1);
        @(posedge clk); #2;
        chk("lvl16_awvalid", m_awvalid, 1);
        chk("lvl16_awaddr", m_awaddr, BASE);
        r0 = n_rd; b0 = n_beats; bc = 1;
        repeat (25) begin
            @(posedge clk); #2;
            if (busy) bc++;
        end
        chk("burst_rd_pulses", n_rd - r0, BL);
        chk("burst_beats", n_beats - b0, BL);
        chk("burst_busy_cycles", bc, BL + 2);

        do_reset();
        aw_delay = 5; rand_w = 1; rand_b = 1; rand_push = 1;
        b0 = n_beats;
        to_push = 10 * BL;
        wait_drain(8000);
        chk("rand_beats", n_beats - b0, 10 * BL);
        chk("rand_words_left", exp_w.size(), 0);
        aw_delay = 0; rand_w = 0; rand_b = 0; rand_push = 0;

        do_reset();
        bad_burst = 1;
        push_n(5 * BL);
        wait_drain(2000);
        chk("frame_bursts", aw_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("frame_addr", i < aw_log.size() ? aw_log[i] : '1, AW'((i % FB) * BYTES));
        chk("err_final", err, CHK);
        bad_burst = -1;

        do_reset();
        push_n(5 * BL);
        n = 0;
        while (!(aw_log.size() == 3 && m_wvalid) && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("restart_reached", n < 2000, 1);
        frame_start = 1'b1; bnum = 0;
        @(posedge clk); #2;
        frame_start = 1'b0;
        wait_drain(2000);
        chk("restart_bursts", aw_log.size(), 5);
        chk("restart_addr3", aw_log.size() > 3 ? aw_log[3] : '1, BASE);
        chk("restart_addr4", aw_log.size() > 4 ? aw_log[4] : '1, BASE + AW'(BYTES));

        do_reset();
        push_n(2 * BL);
        wait_drain(1000);
        frame_start = 1'b1; bnum = 0;
        push_n(BL);
        @(posedge clk); #2;
        frame_start = 1'b0;
        chk("idle_restart_hold", m_awvalid, 0);
        wait_drain(1000);
        chk("idle_restart_addr", aw_log.size() == 3 ? aw_log[2] : '1, BASE);

        do_reset();
        push_n(2 * BL);
        b0 = n_beats; n = 0;
        while (n_beats - b0 < 5 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("midburst_reached", n < 1000, 1);
        do_reset();
        push_n(BL);
        wait_drain(1000);
        chk("post_reset_addr", aw_log.size() == 1 ? aw_log[0] : '1, BASE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_fifo_axi_wr.md
# video_fifo_axi_wr

Drain side of the video ingest FIFO. Reads 256-bit words from the FIFO read port (1-cycle read latency, no output register) and writes them to DDR as fixed-length AXI4 INCR write bursts, advancing a frame address that wraps at the frame size. Sits between the FIFO read port and the DDR controller AXI write slave, in the FIFO read clock domain.

## Interface
Parameters:
- DATA_WIDTH, 256, FIFO read width and AXI data width
- ADDR_WIDTH, 28, AXI byte address width
- LEVEL_WIDTH, 9, width of FIFO read water level
- BURST_LEN, 16, beats per burst (1..256)
- FRAME_BASE, 0, byte address of frame start
- FRAME_BURSTS, 3600, bursts per frame before address wraps

Ports:
- clk  in  1  clock (FIFO read clock)
- tb_rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  pulse: restart at FRAME_BASE
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid cycle after fifo_rd_en
- fifo_rd_water_level  in  LEVEL_WIDTH  words in FIFO
- fifo_rd_en  out  1  FIFO pop
- m_awaddr  out  ADDR_WIDTH; m_awlen  out  8 (constant BURST_LEN-1); m_awvalid out 1; m_awready in 1
- m_wdata  out  DATA_WIDTH; m_wstrb  out  DATA_WIDTH/8 (all ones); m_wlast  out  1; m_wvalid  out  1; m_wready  in  1
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1
- busy  out  1  state != IDLE
- err  out  1  sticky bad write response

## Operation
- States IDLE, ADDR, DATA, RESP.
- IDLE -> ADDR when fifo_rd_water_level >= BURST_LEN and no pending frame restart to apply; m_awvalid=1, m_awaddr=current address.
- ADDR -> DATA on m_awvalid && m_awready. m_awvalid held stable until accepted.
- Prefetch: 2-entry output buffer. fifo_rd_en=1 in ADDR or DATA when (occupancy + reads in flight) < 2 and words fetched this burst < BURST_LEN. Never more than BURST_LEN pops per burst.
- DATA: m_wvalid = buffer non-empty; m_wdata = buffer head; beat counter increments on handshake; m_wlast=1 on beat BURST_LEN-1 (0-based). Last handshake -> RESP.
- RESP: m_bready=1; on m_bvalid -> IDLE; address += BURST_LEN*DATA_WIDTH/8; after FRAME_BURSTS bursts address returns to FRAME_BASE, burst counter to 0.
- frame_start in IDLE: address=FRAME_BASE, burst counter 0 next cycle. In other states: latched pending, applied on RESP->IDLE instead of increment.
- Water-level check guarantees no FIFO underflow; fifo_rd_en never asserted with level 0.

## Timing
- Reset values: fifo_rd_en 0, m_awvalid 0, m_awaddr FRAME_BASE, m_wvalid 0, m_wlast 0, m_wdata 0, m_bready 0, busy 0, err 0; state IDLE, buffer empty.
- Level qualifies in cycle N -> m_awvalid in N+1. First fifo_rd_en in N+1; data in buffer N+2.
- Awready/wready/bvalid all immediate: one burst = 1 (ADDR) + BURST_LEN (DATA) + 1 (RESP) + 1 (IDLE) cycles; W throughput 1 beat/cycle with wready held high.
- m_wready low: m_wvalid, m_wdata, m_wlast held; prefetch stops at 2 buffered.
- m_wvalid never asserted before AW handshake completes.
- Reset mid-burst: all outputs to reset values immediately; partial burst abandoned, FIFO not re-synchronised (FIFO reset on same tb_rst).

## Configuration
- VIDEO_WR_BRESP_CHECK_EN defined: on RESP handshake with m_bresp != 2'b00, err set to 1 and held until tb_rst.
- Undefined: m_bresp ignored, err tied 0.

## Test plan
- Reset: hold tb_rst 200 ns -> every output at reset value, m_awaddr = FRAME_BASE.
- Level 15 then 16 (BURST_LEN 16) -> no AW at 15; m_awvalid next cycle at 16, m_awaddr 0, m_awlen 15, exactly 16 fifo_rd_en pulses, 16 beats, m_wlast on 16th.
- Random wready (50%) and awready delayed 5 cycles -> wdata sequence equals FIFO order, no lost/duplicated word, no wvalid before AW accept.
- FRAME_BURSTS 4, level held high -> addresses 0, 512, 1024, 1536, 0.
- frame_start pulsed in DATA of burst at 1024 -> next burst address 0, not 1536.
- With VIDEO_WR_BRESP_CHECK_EN, bresp 2'b10 on burst 2 -> err=1 from next cycle, stays 1 through further OKAY bursts; without macro err stays 0.
